// File: rtl/fetch_packet_gen.sv
// Fetch front-end: owns the fetch PC, issues one aligned 8-byte I-cache request at a time
// and merges each response with the branch-predictor lookup into a two-slot fetch packet.
module fetch_packet_gen #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter int          FETCH_BYTES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_redirect_valid,
  input  logic [63:0] io_redirect_target,
  output logic        io_icache_req_valid,
  input  logic        io_icache_req_ready,
  output logic [63:0] io_icache_req_addr,
  input  logic        io_icache_resp_valid,
  input  logic [63:0] io_icache_resp_data,
  input  logic        io_bp_valid,
  input  logic        io_bp_taken,
  input  logic        io_bp_select,
  input  logic [63:0] io_bp_target,
  input  logic        io_fq_full,
  output logic        io_out_valid,
  output logic        io_out_bits_valids_0,
  output logic        io_out_bits_valids_1,
  output logic [63:0] io_out_bits_pc,
  output logic [31:0] io_out_bits_insts_0,
  output logic [31:0] io_out_bits_insts_1,
  output logic        io_out_bits_branch_predict_pack_valid,
  output logic        io_out_bits_branch_predict_pack_taken,
  output logic [63:0] io_out_bits_branch_predict_pack_target
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      state;
  logic [63:0] pc_q;
  logic [63:0] pc_al;
  logic [63:0] next_pc;
  logic        slot0_v;
  logic        slot1_v;
  logic        sel_v;

  assign pc_al               = {pc_q[63:3], 3'b000};
  assign io_icache_req_addr  = pc_al;
  assign io_icache_req_valid = (state == S_REQ) & ~io_redirect_valid;
  assign io_out_valid        = (state == S_HOLD) & ~io_fq_full & ~io_redirect_valid;

  // An entry PC in the upper half kills slot 0; a taken branch in slot 0 kills slot 1.
  assign slot0_v = ~pc_q[2];
  assign slot1_v = ~(io_bp_valid & io_bp_taken & ~io_bp_select & slot0_v);
  assign sel_v   = io_bp_select ? slot1_v : slot0_v;

  assign next_pc = (io_out_bits_branch_predict_pack_valid & io_out_bits_branch_predict_pack_taken)
                 ? io_out_bits_branch_predict_pack_target
                 : io_out_bits_pc + 64'(FETCH_BYTES);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                                  <= S_REQ;
      pc_q                                   <= RESET_PC;
      io_out_bits_valids_0                   <= 1'b0;
      io_out_bits_valids_1                   <= 1'b0;
      io_out_bits_pc                         <= '0;
      io_out_bits_insts_0                    <= '0;
      io_out_bits_insts_1                    <= '0;
      io_out_bits_branch_predict_pack_valid  <= 1'b0;
      io_out_bits_branch_predict_pack_taken  <= 1'b0;
      io_out_bits_branch_predict_pack_target <= '0;
    end else if (io_redirect_valid) begin
      pc_q <= io_redirect_target;
      // A request still in flight must have its response swallowed before refetching.
      if ((state == S_WAIT || state == S_DRAIN) && !io_icache_resp_valid)
        state <= S_DRAIN;
      else
        state <= S_REQ;
    end else begin
      case (state)
        S_REQ:   if (io_icache_req_ready) state <= S_WAIT;
        S_WAIT: begin
          if (io_icache_resp_valid) begin
            state                                  <= S_HOLD;
            io_out_bits_pc                         <= pc_al;
            io_out_bits_valids_0                   <= slot0_v;
            io_out_bits_valids_1                   <= slot1_v;
            io_out_bits_insts_0                    <= io_icache_resp_data[31:0];
            io_out_bits_insts_1                    <= io_icache_resp_data[63:32];
            io_out_bits_branch_predict_pack_valid  <= sel_v & io_bp_valid;
            io_out_bits_branch_predict_pack_taken  <= sel_v & io_bp_taken;
            io_out_bits_branch_predict_pack_target <= sel_v ? io_bp_target : 64'd0;
          end
        end
        S_HOLD: begin
          if (!io_fq_full) begin
            state <= S_REQ;
            pc_q  <= next_pc;
          end
        end
        S_DRAIN: if (io_icache_resp_valid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_packet_gen.sv
// Directed + randomized bench for fetch_packet_gen with a transaction-level reference model.
module tb_fetch_packet_gen;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_redirect_valid;
  logic [63:0] io_redirect_target;
  logic        io_icache_req_valid;
  logic        io_icache_req_ready;
  logic [63:0] io_icache_req_addr;
  logic        io_icache_resp_valid;
  logic [63:0] io_icache_resp_data;
  logic        io_bp_valid, io_bp_taken, io_bp_select;
  logic [63:0] io_bp_target;
  logic        io_fq_full;
  logic        io_out_valid;
  logic        io_out_bits_valids_0, io_out_bits_valids_1;
  logic [63:0] io_out_bits_pc;
  logic [31:0] io_out_bits_insts_0, io_out_bits_insts_1;
  logic        io_out_bits_branch_predict_pack_valid, io_out_bits_branch_predict_pack_taken;
  logic [63:0] io_out_bits_branch_predict_pack_target;

  fetch_packet_gen dut (
    .clock(clock), .reset(reset),
    .io_redirect_valid(io_redirect_valid), .io_redirect_target(io_redirect_target),
    .io_icache_req_valid(io_icache_req_valid), .io_icache_req_ready(io_icache_req_ready),
    .io_icache_req_addr(io_icache_req_addr),
    .io_icache_resp_valid(io_icache_resp_valid), .io_icache_resp_data(io_icache_resp_data),
    .io_bp_valid(io_bp_valid), .io_bp_taken(io_bp_taken), .io_bp_select(io_bp_select),
    .io_bp_target(io_bp_target), .io_fq_full(io_fq_full),
    .io_out_valid(io_out_valid),
    .io_out_bits_valids_0(io_out_bits_valids_0), .io_out_bits_valids_1(io_out_bits_valids_1),
    .io_out_bits_pc(io_out_bits_pc),
    .io_out_bits_insts_0(io_out_bits_insts_0), .io_out_bits_insts_1(io_out_bits_insts_1),
    .io_out_bits_branch_predict_pack_valid(io_out_bits_branch_predict_pack_valid),
    .io_out_bits_branch_predict_pack_taken(io_out_bits_branch_predict_pack_taken),
    .io_out_bits_branch_predict_pack_target(io_out_bits_branch_predict_pack_target)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic        v0, v1;
    logic [31:0] i0, i1;
    logic        pv, pt;
    logic [63:0] tgt;
  } pkt_t;

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  logic        redir = 0, full = 0, ready = 0, force_resp = 0, rnd_bp = 0, use_fbp = 0;
  logic [63:0] redir_tgt = 0;
  int          lat_fix = 0;

  // I-cache responder
  logic pend = 0;
  int   cnt = 0;

  // reference model: fetch PC, outstanding/stale request, held packet
  logic [63:0] m_pc = RST_PC;
  logic        m_out = 0, m_stale = 0, m_pkt = 0;
  pkt_t        m_p;

  logic [63:0] req_log[$];
  pkt_t        pkt_log[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] req_at(int i);
    return (req_log.size() > i) ? req_log[i] : 64'hx;
  endfunction

  function automatic pkt_t pkt_at(int i);
    pkt_t p;
    p = '{pc: 64'hx, v0: 1'bx, v1: 1'bx, i0: 32'hx, i1: 32'hx, pv: 1'bx, pt: 1'bx, tgt: 64'hx};
    if (pkt_log.size() > i) p = pkt_log[i];
    return p;
  endfunction

  task automatic tick();
    logic rv, rdr, frq, bv, bt, bs, v0, v1, selv;
    logic [63:0] btg, data;
    pkt_t o;
    @(negedge clock);
    rv   = force_resp | (pend & (cnt == 0));
    data = {$urandom, $urandom};
    if (use_fbp) begin
      bv = 1; bt = 1; bs = 0; btg = 64'h8000_0040;
    end else if (rnd_bp && $urandom_range(1, 0) == 1) begin
      bv = 1; bt = 1'($urandom_range(1, 0)); bs = 1'($urandom_range(1, 0)); btg = {$urandom, $urandom};
    end else begin
      bv = 0; bt = 0; bs = 0; btg = 0;
    end
    io_icache_resp_valid = rv;  io_icache_resp_data = data;
    io_bp_valid = bv; io_bp_taken = bt; io_bp_select = bs; io_bp_target = btg;
    io_redirect_valid = redir;  io_redirect_target = redir_tgt;
    io_fq_full = full;          io_icache_req_ready = ready;
    rdr = redir;
    #1;
    chk("req_valid", 64'(io_icache_req_valid), 64'(!m_out && !m_pkt && !rdr));
    chk("req_addr", io_icache_req_addr, {m_pc[63:3], 3'b000});
    chk("out_valid", 64'(io_out_valid), 64'(m_pkt && !full && !rdr));
    if (m_pkt) begin
      chk("pkt_pc", io_out_bits_pc, m_p.pc);
      chk("pkt_v0", 64'(io_out_bits_valids_0), 64'(m_p.v0));
      chk("pkt_v1", 64'(io_out_bits_valids_1), 64'(m_p.v1));
      chk("pkt_i0", 64'(io_out_bits_insts_0), 64'(m_p.i0));
      chk("pkt_i1", 64'(io_out_bits_insts_1), 64'(m_p.i1));
      chk("pkt_pv", 64'(io_out_bits_branch_predict_pack_valid), 64'(m_p.pv));
      chk("pkt_pt", 64'(io_out_bits_branch_predict_pack_taken), 64'(m_p.pt));
      chk("pkt_tgt", io_out_bits_branch_predict_pack_target, m_p.tgt);
    end
    frq = io_icache_req_valid & io_icache_req_ready;
    if (io_out_valid) begin
      o = '{pc: io_out_bits_pc, v0: io_out_bits_valids_0, v1: io_out_bits_valids_1,
            i0: io_out_bits_insts_0, i1: io_out_bits_insts_1,
            pv: io_out_bits_branch_predict_pack_valid, pt: io_out_bits_branch_predict_pack_taken,
            tgt: io_out_bits_branch_predict_pack_target};
      pkt_log.push_back(o);
    end
    if (frq) req_log.push_back(io_icache_req_addr);
    // model update
    if (rdr) begin
      m_pc  = redir_tgt;
      m_pkt = 0;
      if (m_out) begin
        if (rv) begin m_out = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else if (m_pkt) begin
      if (!full) begin
        m_pkt = 0;
        m_pc  = (m_p.pv && m_p.pt) ? m_p.tgt : {m_pc[63:3], 3'b000} + 64'd8;
      end
    end else if (m_out) begin
      if (rv) begin
        m_out = 0;
        if (!m_stale) begin
          v0   = !m_pc[2];
          v1   = !(bv && bt && !bs && v0);
          selv = bs ? v1 : v0;
          m_p  = '{pc: {m_pc[63:3], 3'b000}, v0: v0, v1: v1, i0: data[31:0], i1: data[63:32],
                   pv: selv & bv, pt: selv & bt, tgt: selv ? btg : 64'd0};
          m_pkt = 1;
        end
        m_stale = 0;
      end
    end else if (ready) begin
      m_out = 1;
    end
    // responder update
    if (pend) begin
      if (cnt == 0) pend = 0;
      else cnt--;
    end
    if (frq) begin
      pend = 1;
      cnt  = (lat_fix >= 0) ? lat_fix : $urandom_range(2, 0);
    end
    redir = 0; force_resp = 0;
  endtask

  initial begin
    int n;
    pkt_t p;
    reset = 1; io_redirect_valid = 0; io_redirect_target = 0; io_icache_req_ready = 0;
    io_icache_resp_valid = 0; io_icache_resp_data = 0; io_bp_valid = 0; io_bp_taken = 0;
    io_bp_select = 0; io_bp_target = 0; io_fq_full = 0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_out_valid", 64'(io_out_valid), 0);
    chk("rst_pc", io_out_bits_pc, 0);
    chk("rst_valids", 64'({io_out_bits_valids_0, io_out_bits_valids_1}), 0);
    chk("rst_insts", {io_out_bits_insts_1, io_out_bits_insts_0}, 0);
    chk("rst_req_addr", io_icache_req_addr, RST_PC);
    reset = 0;

    // sequential fetch, 1-cycle cache
    ready = 1; lat_fix = 0;
    for (int i = 0; i < 40 && pkt_log.size() < 3; i++) tick();
    chk("seq_req0", req_at(0), 64'h8000_0000);
    chk("seq_req1", req_at(1), 64'h8000_0008);
    chk("seq_req2", req_at(2), 64'h8000_0010);
    for (int k = 0; k < 3; k++) begin
      p = pkt_at(k);
      chk("seq_pkt_pc", p.pc, 64'h8000_0000 + 64'(8 * k));
      chk("seq_pkt_valids", 64'({p.v0, p.v1}), 64'b11);
    end

    // redirect to an upper-half target
    req_log.delete(); pkt_log.delete();
    redir = 1; redir_tgt = 64'h8000_0104;
    for (int i = 0; i < 40 && pkt_log.size() < 1; i++) tick();
    p = pkt_at(0);
    chk("unal_req", req_at(0), 64'h8000_0100);
    chk("unal_pc", p.pc, 64'h8000_0100);
    chk("unal_valids", 64'({p.v0, p.v1}), 64'b01);

    // taken branch predicted in slot 0
    req_log.delete(); pkt_log.delete();
    redir = 1; redir_tgt = 64'h8000_0000; use_fbp = 1;
    for (int i = 0; i < 40 && pkt_log.size() < 1; i++) tick();
    use_fbp = 0;
    for (int i = 0; i < 40 && req_log.size() < 2; i++) tick();
    p = pkt_at(0);
    chk("bp_valids", 64'({p.v0, p.v1}), 64'b10);
    chk("bp_pack", 64'({p.pv, p.pt}), 64'b11);
    chk("bp_tgt", p.tgt, 64'h8000_0040);
    chk("bp_next_req", req_at(1), 64'h8000_0040);

    // queue full holds the packet and blocks new requests
    full = 1;
    for (int i = 0; i < 40 && !m_pkt; i++) tick();
    chk("full_have_pkt", 64'(m_pkt), 1);
    n = pkt_log.size(); req_log.delete();
    repeat (5) tick();
    chk("full_no_out", 64'(pkt_log.size()), 64'(n));
    chk("full_no_req", 64'(req_log.size()), 0);
    full = 0;
    tick();
    chk("full_release_out", 64'(pkt_log.size()), 64'(n + 1));
    for (int i = 0; i < 10 && req_log.size() < 1; i++) tick();
    chk("full_next_req", 64'(req_log.size()), 1);

    // redirect while waiting on a slow response
    lat_fix = 3;
    for (int i = 0; i < 40 && !(m_out && !m_pkt); i++) tick();
    n = pkt_log.size(); req_log.delete();
    redir = 1; redir_tgt = 64'h9000_0000;
    for (int i = 0; i < 40 && req_log.size() < 1; i++) tick();
    chk("drain_no_pkt", 64'(pkt_log.size()), 64'(n));
    chk("drain_req", req_at(0), 64'h9000_0000);

    // randomized traffic
    lat_fix = -1; rnd_bp = 1;
    for (int i = 0; i < 600; i++) begin
      full  = ($urandom_range(3, 0) == 0);
      ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(19, 0) == 0) begin
        redir = 1; redir_tgt = {$urandom, $urandom};
      end
      tick();
    end
    rnd_bp = 0; ready = 1;

    // reset while holding a packet, then a stray response
    full = 1;
    for (int i = 0; i < 40 && !m_pkt; i++) tick();
    chk("hold_before_rst", 64'(m_pkt), 1);
    @(negedge clock);
    reset = 1;
    #1;
    chk("mid_rst_out_valid", 64'(io_out_valid), 0);
    chk("mid_rst_pc", io_out_bits_pc, 0);
    chk("mid_rst_valids", 64'({io_out_bits_valids_0, io_out_bits_valids_1}), 0);
    chk("mid_rst_pack", 64'(io_out_bits_branch_predict_pack_valid), 0);
    chk("mid_rst_req_addr", io_icache_req_addr, RST_PC);
    m_pc = RST_PC; m_out = 0; m_stale = 0; m_pkt = 0; pend = 0;
    @(posedge clock); #1;
    reset = 0; full = 0; ready = 0;
    req_log.delete(); pkt_log.delete();
    force_resp = 1;
    repeat (3) tick();
    chk("stray_no_pkt", 64'(pkt_log.size()), 0);
    ready = 1; lat_fix = 0;
    for (int i = 0; i < 20 && pkt_log.size() < 1; i++) tick();
    chk("post_rst_req", req_at(0), RST_PC);
    chk("post_rst_pkt_pc", pkt_at(0).pc, RST_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
